riscv_multicycle_control: RTL and testbench

- Control unit driving the simple single-issue RISC-V datapath from the other side of its control interface.
- Consumes the fetched instruction and the datapath's ALU Zero flag.
- Sequences each instruction through a fixed 5-state FSM: IF, ID, EX, MEM, WB.
- Produces every datapath control strobe (PCSrc, ALUSrc, RegWrite, MemtoReg, loadPC, ALUCtrl) plus the instruction- and data-memory strobes.

---
 rtl/riscv_multicycle_control_pkg.sv | 46 ++++
 rtl/riscv_multicycle_control_if.sv | 30 +++
 rtl/riscv_multicycle_control_decode.sv | 105 ++++++++++
 rtl/riscv_multicycle_control.sv | 73 +++++++
 tb/tb_riscv_multicycle_control.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/riscv_multicycle_control_pkg.sv
// Shared constants for the multicycle RISC-V control unit and its datapath.
// Holds opcode, funct3 and ALUCtrl encodings, plus the FSM state type.
package riscv_datapath_constants;

    // Opcodes
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    // funct3 values
    localparam logic [2:0] F3AddSub = 3'b000;
    localparam logic [2:0] F3Sll    = 3'b001;
    localparam logic [2:0] F3Slt    = 3'b010;
    localparam logic [2:0] F3Xor    = 3'b100;
    localparam logic [2:0] F3Srl    = 3'b101;
    localparam logic [2:0] F3Or     = 3'b110;
    localparam logic [2:0] F3And    = 3'b111;
    localparam logic [2:0] F3Lw     = 3'b010;
    localparam logic [2:0] F3Sw     = 3'b010;
    localparam logic [2:0] F3Beq    = 3'b000;

    // funct7 value selecting sub/sra
    localparam logic [6:0] F7Alt = 7'b0100000;

    // ALUCtrl codes
    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluLt  = 4'b0111;
    localparam logic [3:0] AluSrl = 4'b1000;
    localparam logic [3:0] AluSll = 4'b1001;
    localparam logic [3:0] AluSra = 4'b1010;
    localparam logic [3:0] AluXor = 4'b1101;

    typedef enum logic [2:0] {
        StIf  = 3'd0,
        StId  = 3'd1,
        StEx  = 3'd2,
        StMem = 3'd3,
        StWb  = 3'd4
    } state_t;

endpackage

// File: rtl/riscv_multicycle_control_if.sv
// Control interface between the multicycle control unit and the datapath.
// master: control unit (consumes instruction/Zero, drives all strobes and state).
// slave:  datapath side (drives instruction/Zero, consumes strobes).
interface riscv_multicycle_control_if;
    logic [31:0] instruction;
    logic        Zero;
    logic        iMemRead;
    logic        ALUSrc;
    logic [3:0]  ALUCtrl;
    logic        MemRead;
    logic        MemWrite;
    logic        MemtoReg;
    logic        RegWrite;
    logic        PCSrc;
    logic        loadPC;
    logic        illegal_op;
    logic [2:0]  state;

    modport master (
        input  instruction, Zero,
        output iMemRead, ALUSrc, ALUCtrl, MemRead, MemWrite, MemtoReg,
               RegWrite, PCSrc, loadPC, illegal_op, state
    );

    modport slave (
        output instruction, Zero,
        input  iMemRead, ALUSrc, ALUCtrl, MemRead, MemWrite, MemtoReg,
               RegWrite, PCSrc, loadPC, illegal_op, state
    );
endinterface

// File: rtl/riscv_multicycle_control_decode.sv
// Purely combinational instruction decode.
// Inputs:  opcode, funct3, funct7 fields of the instruction.
// Outputs: alu_ctrl, alu_src, mem_to_reg, pc_src, illegal_op, and class flags
//          is_load / is_store / writes_reg used by the top-level state gating.
module riscv_control_decode
    import riscv_datapath_constants::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_ctrl,
    output logic       alu_src,
    output logic       mem_to_reg,
    output logic       pc_src,
    output logic       illegal_op,
    output logic       is_load,
    output logic       is_store,
    output logic       writes_reg
);

    always_comb begin
        alu_ctrl   = AluAdd;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = 1'b0;
        illegal_op = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        writes_reg = 1'b0;

        case (opcode)
            OpR: begin
                writes_reg = 1'b1;
                case (funct3)
                    F3AddSub: alu_ctrl = funct7[5] ? AluSub : AluAdd;
                    F3Sll:    alu_ctrl = AluSll;
                    F3Slt:    alu_ctrl = AluLt;
                    F3Xor:    alu_ctrl = AluXor;
                    F3Srl:    alu_ctrl = funct7[5] ? AluSra : AluSrl;
                    F3Or:     alu_ctrl = AluOr;
                    F3And:    alu_ctrl = AluAnd;
                    default:  illegal_op = 1'b1;
                endcase
                // The alternate funct7 only exists for sub and sra.
                if (funct7 != 7'b0000000 &&
                    !(funct7 == F7Alt && (funct3 == F3AddSub || funct3 == F3Srl))) begin
                    illegal_op = 1'b1;
                end
            end
            OpIAlu: begin
                alu_src    = 1'b1;
                writes_reg = 1'b1;
                case (funct3)
                    F3AddSub: alu_ctrl = AluAdd;
                    F3Sll:    alu_ctrl = AluSll;
                    F3Slt:    alu_ctrl = AluLt;
                    F3Xor:    alu_ctrl = AluXor;
                    F3Srl:    alu_ctrl = funct7[5] ? AluSra : AluSrl;
                    F3Or:     alu_ctrl = AluOr;
                    F3And:    alu_ctrl = AluAnd;
                    default:  illegal_op = 1'b1;
                endcase
            end
            OpLoad: begin
                if (funct3 == F3Lw) begin
                    alu_src    = 1'b1;
                    mem_to_reg = 1'b1;
                    is_load    = 1'b1;
                    writes_reg = 1'b1;
                end else begin
                    illegal_op = 1'b1;
                end
            end
            OpStore: begin
                if (funct3 == F3Sw) begin
                    alu_src  = 1'b1;
                    is_store = 1'b1;
                end else begin
                    illegal_op = 1'b1;
                end
            end
            OpBranch: begin
                if (funct3 == F3Beq) begin
                    alu_ctrl = AluSub;
                    pc_src   = 1'b1;
                end else begin
                    illegal_op = 1'b1;
                end
            end
            default: illegal_op = 1'b1;
        endcase

        // Illegal instructions fall back to a harmless PC+4 with no side effects.
        if (illegal_op) begin
            alu_ctrl   = AluAdd;
            alu_src    = 1'b0;
            mem_to_reg = 1'b0;
            pc_src     = 1'b0;
            is_load    = 1'b0;
            is_store   = 1'b0;
            writes_reg = 1'b0;
        end
    end

endmodule

// File: rtl/riscv_multicycle_control.sv
// Multicycle RISC-V control unit: fixed IF->ID->EX->MEM->WB sequence per
// instruction, state-gated memory/register/PC strobes, decode outputs passed
// straight through.
// Ports: clk, rst (synchronous, active-high); ctrl (master side of the control
// interface: instruction/Zero in, all control strobes and debug state out).
module riscv_multicycle_control
    import riscv_datapath_constants::*;
(
    input  logic                        clk,
    input  logic                        rst,
    riscv_multicycle_control_if.master  ctrl
);

    state_t state_q, state_d;
    logic   is_load, is_store, writes_reg;

    // Zero is consumed by the datapath's branch gating (loadPC & PCSrc & Zero).
    logic unused_zero;
    assign unused_zero = ctrl.Zero;

    riscv_control_decode u_decode (
        .opcode     (ctrl.instruction[6:0]),
        .funct3     (ctrl.instruction[14:12]),
        .funct7     (ctrl.instruction[31:25]),
        .alu_ctrl   (ctrl.ALUCtrl),
        .alu_src    (ctrl.ALUSrc),
        .mem_to_reg (ctrl.MemtoReg),
        .pc_src     (ctrl.PCSrc),
        .illegal_op (ctrl.illegal_op),
        .is_load    (is_load),
        .is_store   (is_store),
        .writes_reg (writes_reg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIf;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StIf;
        unique case (state_q)
            StIf:    state_d = StId;
            StId:    state_d = StEx;
            StEx:    state_d = StMem;
            StMem:   state_d = StWb;
            StWb:    state_d = StIf;
            default: state_d = StIf;
        endcase
    end

    // Strobes are masked by rst directly so a mid-instruction reset has no side effect.
    always_comb begin
        ctrl.iMemRead = 1'b0;
        ctrl.MemRead  = 1'b0;
        ctrl.MemWrite = 1'b0;
        ctrl.RegWrite = 1'b0;
        ctrl.loadPC   = 1'b0;
        if (!rst) begin
            ctrl.iMemRead = (state_q == StIf);
            ctrl.MemRead  = (state_q == StMem) && is_load;
            ctrl.MemWrite = (state_q == StMem) && is_store;
            ctrl.RegWrite = (state_q == StWb) && writes_reg;
            ctrl.loadPC   = (state_q == StWb);
        end
    end

    assign ctrl.state = state_q;

endmodule

// File: tb/tb_riscv_multicycle_control.sv
module tb_riscv_multicycle_control;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    riscv_multicycle_control_if bus ();

    riscv_multicycle_control dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    // Reference: a table of instruction patterns (mask/match) with their
    // architectural control attributes; anything that matches nothing is illegal.
    typedef struct packed {
        logic [31:0] mask;
        logic [31:0] match;
        logic [3:0]  alu;
        logic        alusrc;
        logic        memtoreg;
        logic        pcsrc;
        logic        wr;
        logic        ld;
        logic        st;
        logic        ill;
    } pat_t;

    localparam int NPats = 19;
    pat_t pats [NPats] = '{
        '{32'hFE00707F, 32'h00000033, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, // add
        '{32'hFE00707F, 32'h40000033, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, // sub
        '{32'hFE00707F, 32'h00001033, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, // sll
        '{32'hFE00707F, 32'h00002033, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, // slt
        '{32'hFE00707F, 32'h00004033, 4'b1101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, // xor
        '{32'hFE00707F, 32'h00005033, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, // srl
        '{32'hFE00707F, 32'h40005033, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, // sra
        '{32'hFE00707F, 32'h00006033, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, // or
        '{32'hFE00707F, 32'h00007033, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, // and
        '{32'h0000707F, 32'h00000013, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, // addi
        '{32'h0000707F, 32'h00002013, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, // slti
        '{32'h0000707F, 32'h00004013, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, // xori
        '{32'h0000707F, 32'h00006013, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, // ori
        '{32'h0000707F, 32'h00007013, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, // andi
        '{32'h0000707F, 32'h00001013, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, // slli
        '{32'h4000707F, 32'h00005013, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, // srli
        '{32'h4000707F, 32'h40005013, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, // srai
        '{32'h0000707F, 32'h00002003, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}, // lw
        '{32'h0000707F, 32'h00002023, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}  // sw
    };
    pat_t beq_pat = '{32'h0000707F, 32'h00000063, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0,
                      1'b0, 1'b0, 1'b0};

    function automatic pat_t model(input logic [31:0] instr);
        pat_t e;
        e = '{32'h0, 32'h0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < NPats; k++) begin
            if ((instr & pats[k].mask) == pats[k].match) e = pats[k];
        end
        if ((instr & beq_pat.mask) == beq_pat.match) e = beq_pat;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one instruction from its IF cycle; abort_at (0..4) raises rst in that phase.
    task automatic run_instr(input logic [31:0] instr, input int abort_at);
        pat_t e;
        bit   in_rst;
        e = model(instr);
        bus.instruction = instr;
        bus.Zero        = 1'($urandom_range(0, 1));
        for (int ph = 0; ph < 5; ph++) begin
            in_rst = (ph == abort_at);
            if (in_rst) rst = 1'b1;
            @(negedge clk);
            check("state",    32'(bus.state),    32'(ph));
            check("iMemRead", 32'(bus.iMemRead), 32'(!in_rst && ph == 0));
            check("MemRead",  32'(bus.MemRead),  32'(!in_rst && ph == 3 && e.ld));
            check("MemWrite", 32'(bus.MemWrite), 32'(!in_rst && ph == 3 && e.st));
            check("RegWrite", 32'(bus.RegWrite), 32'(!in_rst && ph == 4 && e.wr));
            check("loadPC",   32'(bus.loadPC),   32'(!in_rst && ph == 4));
            if (ph != 0) begin
                check("ALUCtrl",    32'(bus.ALUCtrl),    32'(e.alu));
                check("ALUSrc",     32'(bus.ALUSrc),     32'(e.alusrc));
                check("MemtoReg",   32'(bus.MemtoReg),   32'(e.memtoreg));
                check("PCSrc",      32'(bus.PCSrc),      32'(e.pcsrc));
                check("illegal_op", 32'(bus.illegal_op), 32'(e.ill));
            end
            @(posedge clk);
            #1;
            if (in_rst) begin
                rst = 1'b0;
                return;
            end
        end
    endtask

    logic [31:0] directed [7] = '{
        32'h002081B3, // add x3,x1,x2
        32'h40335293, // srai x5,x6,3
        32'h402081B3, // sub x3,x1,x2
        32'h00812203, // lw x4,8(x2)
        32'h00412423, // sw x4,8(x2)
        32'h00208863, // beq x1,x2,+16
        32'hFFFFFFFF  // illegal
    };

    initial begin
        logic [31:0] instr;
        int          k;
        n_cmp  = 0;
        n_fail = 0;
        rst             = 1'b1;
        bus.instruction = $urandom;
        bus.Zero        = 1'b0;

        // Reset held for 3 cycles: strobes forced low regardless of state.
        repeat (3) begin
            @(negedge clk);
            check("rst_iMemRead", 32'(bus.iMemRead), 32'd0);
            check("rst_MemRead",  32'(bus.MemRead),  32'd0);
            check("rst_MemWrite", 32'(bus.MemWrite), 32'd0);
            check("rst_RegWrite", 32'(bus.RegWrite), 32'd0);
            check("rst_loadPC",   32'(bus.loadPC),   32'd0);
            @(posedge clk);
            #1;
            bus.instruction = $urandom;
        end
        check("rst_state", 32'(bus.state), 32'd0);
        rst = 1'b0;

        foreach (directed[i]) run_instr(directed[i], 5);

        // Reset during MEM of a store: no MemWrite, back to IF.
        run_instr(32'h00412423, 3);
        run_instr(32'h002081B3, 5);

        for (int n = 0; n < 40; n++) begin
            k = int'($urandom_range(0, NPats + 9));
            if (k < NPats) instr = ($urandom & ~pats[k].mask) | pats[k].match;
            else if (k == NPats) instr = ($urandom & ~beq_pat.mask) | beq_pat.match;
            else instr = $urandom;
            run_instr(instr, (n % 13 == 7) ? int'($urandom_range(0, 4)) : 5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
